proj1_cpu: RTL and testbench

Single-cycle 32-bit MIPS-subset processor core that fetches from and loads/stores to an external combinational `Memory` block. It holds the program counter, a 32×32 register file, the ALU and the main/ALU control decode. One instruction completes per `clk` cycle. It sits between the system clock/reset and the shared instruction/data memory.

---
 rtl/proj1_pkg.sv | 46 ++++
 rtl/proj1_regfile.sv | 32 +++
 rtl/proj1_cpu.sv | 149 ++++++++++++++
 tb/tb_proj1_cpu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj1_pkg.sv
// Shared decode constants, ALU operation enum and control-word layout for proj1_cpu.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proj1_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    // Per-instruction control word produced by the main decoder
    typedef struct packed {
        logic    reg_write;
        logic    reg_dst_rd;
        logic    alu_src_imm;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/proj1_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 reads as zero.
// Latency: reads are combinational; a write is visible from the cycle after its edge.
// Backpressure: none; a write is accepted on every enabled edge.
module proj1_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [0:31];

    // Clear every register on reset; otherwise commit the write, never touching $0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];

endmodule

// File: rtl/proj1_cpu.sv
// Single-cycle MIPS-subset core: PC, decode, ALU and write-back around proj1_regfile.
// Latency: one instruction per clk; memory access and write-back complete in the same cycle.
// Backpressure: none; instruction/data memory is combinational and always ready.
module proj1_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_addr,
    input  logic [31:0] instr,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] data_out
);
    import proj1_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] wb_data;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  wr_addr;
    logic        unused_shamt;
    ctrl_t       ctrl;

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];
    assign imm_ext      = sign_ext(instr[15:0]);

    // Main/ALU decode; anything unrecognised stays an all-zero NOP, and reset kills all side effects
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst_rd = 1'b1;
                ctrl.reg_write  = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
        end
    end

    assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_data;

    // ALU: wrap-around arithmetic, signed set-less-than
    always_comb begin
        alu_result = rs_data + alu_b;
        case (ctrl.alu_op)
            ALU_ADD: alu_result = rs_data + alu_b;
            ALU_SUB: alu_result = rs_data - alu_b;
            ALU_AND: alu_result = rs_data & alu_b;
            ALU_OR:  alu_result = rs_data | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
            default: alu_result = rs_data + alu_b;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    // Next-PC select: jump, taken branch, or fall-through
    always_comb begin
        next_pc = pc_plus4;
        if (ctrl.jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (ctrl.branch && (rs_data == rt_data)) begin
            next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    // PC register; reset returns fetch to address 0 on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    assign wr_addr = ctrl.reg_dst_rd ? rd : rt;
    assign wb_data = ctrl.mem_to_reg ? data_out : alu_result;

    proj1_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (ctrl.reg_write),
        .wr_addr (wr_addr),
        .wr_data (wb_data)
    );

    assign inst_addr = pc;
    assign data_addr = alu_result;
    assign data_in   = rt_data;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;

endmodule

// File: tb/tb_proj1_cpu.sv
// Bench for proj1_cpu: combinational instruction/data memories, directed program table,
// hand-written reset sequences, then random programs against an instruction-level model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_proj1_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr    = imem[inst_addr[9:2]];
    assign data_out = dmem[data_addr[9:2]];

    proj1_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .inst_addr (inst_addr),
        .instr     (instr),
        .data_addr (data_addr),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_out  (data_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory side of a store: performed just before the rising edge that ends the cycle
    task automatic mem_commit();
        if (mem_write) dmem[data_addr[9:2]] = data_in;
    endtask

    function automatic logic [31:0] ii(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] jj(input int tgt);
        return {6'h02, tgt[25:0]};
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rd;
        logic        wr;
        logic        ca;
        logic [31:0] addr;
        logic [31:0] din;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int pc, input logic [31:0] ins, input bit rd, input bit wr,
                       input bit ca, input int addr, input int din);
        vec_t v;
        v.pc = pc; v.ins = ins; v.rd = rd; v.wr = wr; v.ca = ca;
        v.addr = addr; v.din = din;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_ins();
        int k;
        int v;
        int rs, rt, rd;
        k  = int'($urandom_range(0, 11));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case (k)
            0: return rr(rs, rt, rd, 32'h20);
            1: return rr(rs, rt, rd, 32'h22);
            2: return rr(rs, rt, rd, 32'h24);
            3: return rr(rs, rt, rd, 32'h25);
            4: return rr(rs, rt, rd, 32'h2A);
            5: return ii(32'h08, rs, rt, int'($urandom_range(0, 65535)));
            6: return ii(32'h23, rs, rt, int'($urandom_range(0, 65535)));
            7: return ii(32'h2B, rs, rt, int'($urandom_range(0, 65535)));
            8: return ii(32'h04, rs, rt, int'($urandom_range(0, 12)) - 4);
            9: return jj(int'($urandom_range(0, 255)));
            10: begin
                v = int'($urandom_range(1, 63));
                while (v == 2 || v == 4 || v == 8 || v == 32'h23 || v == 32'h2B)
                    v = int'($urandom_range(1, 63));
                return ii(v, rs, rt, int'($urandom_range(0, 65535)));
            end
            default: begin
                v = int'($urandom_range(0, 63));
                while (v == 32'h20 || v == 32'h22 || v == 32'h24 || v == 32'h25 || v == 32'h2A)
                    v = int'($urandom_range(0, 63));
                return rr(rs, rt, rd, v);
            end
        endcase
    endfunction

    // Instruction-level reference model state
    logic [31:0] m_regs [0:31];
    logic [31:0] m_dmem [0:255];
    logic [31:0] m_pc;
    logic [31:0] e_ins, a, b, sx, e_res, e_next, e_wb;
    logic [4:0]  e_dst;
    logic        e_rd, e_wr, e_we, e_ca;

    initial begin
        // ---------------- Reset behaviour and reset during a store ----------------
        for (int i = 0; i < 256; i++) begin imem[i] = 32'd0; dmem[i] = 32'd0; end
        imem[0] = ii(32'h2B, 0, 0, 32'h40);
        imem[1] = ii(32'h08, 0, 1, 32'h55);
        imem[2] = ii(32'h2B, 0, 1, 32'h44);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst%0d inst_addr", c), inst_addr, 32'h0);
            chk($sformatf("rst%0d mem_write", c), 32'(mem_write), 32'h0);
            chk($sformatf("rst%0d mem_read", c), 32'(mem_read), 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rel inst_addr", inst_addr, 32'h0);
        chk("rel sw strobe", 32'(mem_write), 32'h1);
        mem_commit();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel+1 inst_addr", inst_addr, 32'h4);
        mem_commit();
        @(posedge clk); #1;
        @(negedge clk);
        chk("presw mem_write", 32'(mem_write), 32'h1);
        chk("presw data_in", data_in, 32'h55);
        reset = 1'b1;
        #1;
        chk("abort mem_write", 32'(mem_write), 32'h0);
        mem_commit();
        @(posedge clk); #1;
        chk("abort inst_addr", inst_addr, 32'h0);
        chk("abort no store", dmem[32'h44 >> 2], 32'h0);
        imem[0] = ii(32'h2B, 0, 1, 32'h48);
        reset = 1'b0;
        @(negedge clk);
        chk("abort regs cleared", data_in, 32'h0);
        chk("abort post sw addr", data_addr, 32'h48);

        // ---------------- Directed program table ----------------
        add(32'h00, ii(8, 0, 1, 5),            0, 0, 1, 5, 0);
        add(32'h04, ii(8, 0, 2, -3),           0, 0, 1, -3, 0);
        add(32'h08, jj(32'h20),                0, 0, 0, 0, 0);
        add(32'h80, rr(1, 2, 3, 32'h20),       0, 0, 1, 2, 0);
        add(32'h84, rr(1, 2, 4, 32'h22),       0, 0, 1, 8, 0);
        add(32'h88, rr(2, 1, 5, 32'h2A),       0, 0, 1, 1, 0);
        add(32'h8C, ii(8, 0, 0, 7),            0, 0, 1, 7, 0);
        add(32'h90, ii(32'h2B, 0, 3, 32'h200), 0, 1, 1, 32'h200, 2);
        add(32'h94, ii(32'h2B, 0, 4, 32'h204), 0, 1, 1, 32'h204, 8);
        add(32'h98, ii(32'h2B, 0, 5, 32'h208), 0, 1, 1, 32'h208, 1);
        add(32'h9C, ii(32'h2B, 0, 0, 32'h20C), 0, 1, 1, 32'h20C, 0);
        add(32'hA0, ii(8, 0, 1, 32'h40),       0, 0, 1, 32'h40, 0);
        add(32'hA4, ii(32'h2B, 0, 1, 8),       0, 1, 1, 8, 32'h40);
        add(32'hA8, ii(32'h23, 0, 6, 8),       1, 0, 1, 8, 0);
        add(32'hAC, ii(32'h2B, 0, 6, 12),      0, 1, 1, 12, 32'h40);
        add(32'hB0, 32'hFC07_0001,             0, 0, 0, 0, 0);
        add(32'hB4, ii(32'h2B, 0, 7, 16),      0, 1, 1, 16, 0);
        add(32'hB8, rr(1, 1, 8, 32'h21),       0, 0, 0, 0, 0);
        add(32'hBC, ii(32'h2B, 0, 8, 20),      0, 1, 1, 20, 0);
        add(32'hC0, jj(4),                     0, 0, 0, 0, 0);
        add(32'h10, ii(4, 0, 0, 2),            0, 0, 0, 0, 0);
        add(32'h1C, ii(8, 0, 9, 1),            0, 0, 1, 1, 0);
        add(32'h20, ii(8, 0, 10, 2),           0, 0, 1, 2, 0);
        add(32'h24, ii(4, 9, 10, 3),           0, 0, 0, 0, 0);
        add(32'h28, ii(32'h23, 0, 11, 12),     1, 0, 1, 12, 0);
        add(32'h2C, ii(8, 11, 12, 1),          0, 0, 1, 32'h41, 0);
        add(32'h30, rr(1, 2, 13, 32'h2A),      0, 0, 1, 0, 0);
        add(32'h34, rr(2, 1, 14, 32'h22),      0, 0, 1, -67, 0);
        for (int r = 0; r < 3; r++) add(32'h38, ii(4, 0, 0, -1), 0, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) begin imem[i] = 32'd0; dmem[i] = 32'd0; end
        foreach (tbl[i]) imem[tbl[i].pc[9:2]] = tbl[i].ins;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("dir%0d inst_addr", i), inst_addr, tbl[i].pc);
            chk($sformatf("dir%0d mem_read", i), 32'(mem_read), 32'(tbl[i].rd));
            chk($sformatf("dir%0d mem_write", i), 32'(mem_write), 32'(tbl[i].wr));
            if (tbl[i].ca) chk($sformatf("dir%0d data_addr", i), data_addr, tbl[i].addr);
            if (tbl[i].wr) chk($sformatf("dir%0d data_in", i), data_in, tbl[i].din);
            mem_commit();
            @(posedge clk); #1;
        end

        // ---------------- Random programs vs. reference model ----------------
        for (int i = 0; i < 256; i++) begin
            imem[i]   = rand_ins();
            dmem[i]   = $urandom;
            m_dmem[i] = dmem[i];
        end
        reset = 1'b1;
        @(posedge clk); #1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            e_ins  = imem[m_pc[9:2]];
            a      = m_regs[e_ins[25:21]];
            b      = m_regs[e_ins[20:16]];
            sx     = {{16{e_ins[15]}}, e_ins[15:0]};
            e_next = m_pc + 32'd4;
            e_res  = 32'd0;
            e_dst  = e_ins[20:16];
            e_rd = 1'b0; e_wr = 1'b0; e_we = 1'b0; e_ca = 1'b0;
            case (e_ins[31:26])
                6'h00: begin
                    e_dst = e_ins[15:11];
                    e_we  = 1'b1;
                    e_ca  = 1'b1;
                    case (e_ins[5:0])
                        6'h20: e_res = a + b;
                        6'h22: e_res = a - b;
                        6'h24: e_res = a & b;
                        6'h25: e_res = a | b;
                        6'h2A: e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: begin e_we = 1'b0; e_ca = 1'b0; end
                    endcase
                end
                6'h08: begin e_res = a + sx; e_we = 1'b1; e_ca = 1'b1; end
                6'h23: begin e_res = a + sx; e_we = 1'b1; e_ca = 1'b1; e_rd = 1'b1; end
                6'h2B: begin e_res = a + sx; e_wr = 1'b1; e_ca = 1'b1; end
                6'h04: if (a == b) e_next = m_pc + 32'd4 + (sx << 2);
                6'h02: e_next = {e_next[31:28], e_ins[25:0], 2'b00};
                default: ;
            endcase
            e_wb = e_rd ? m_dmem[e_res[9:2]] : e_res;
            chk($sformatf("rnd%0d inst_addr", c), inst_addr, m_pc);
            if (reset) begin
                chk($sformatf("rnd%0d rst mem_read", c), 32'(mem_read), 32'h0);
                chk($sformatf("rnd%0d rst mem_write", c), 32'(mem_write), 32'h0);
            end else begin
                chk($sformatf("rnd%0d mem_read", c), 32'(mem_read), 32'(e_rd));
                chk($sformatf("rnd%0d mem_write", c), 32'(mem_write), 32'(e_wr));
                if (e_ca) chk($sformatf("rnd%0d data_addr", c), data_addr, e_res);
                if (e_wr) chk($sformatf("rnd%0d data_in", c), data_in, b);
            end
            mem_commit();
            @(posedge clk);
            if (reset) begin
                m_pc = 32'd0;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            end else begin
                if (e_wr) m_dmem[e_res[9:2]] = b;
                if (e_we && e_dst != 5'd0) m_regs[e_dst] = e_wb;
                m_pc = e_next;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
